// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter sharing one combinational FP16 multiplier between NUM_REQ
// requesters. Products are tagged with the requester id and queued in a result
// FIFO with a registered head. A sticky register accumulates the class flags of
// every accepted operation.
module fp16_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic [15:0]             mul_a,
  output logic [15:0]             mul_b,
  input  logic [15:0]             mul_p,
  input  logic [5:0]              mul_flags,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [15:0]             rsp_p,
  output logic [5:0]              rsp_flags,
  output logic [ID_W-1:0]         rsp_id,
  output logic [5:0]              sticky_flags,
  input  logic                    sticky_clr,
  output logic [CNT_W-1:0]        fifo_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned EntW = 16 + 6 + ID_W;

  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [EntW-1:0]      head_q, head_d;
  logic [5:0]           sticky_q, sticky_d;
  logic [EntW-1:0]      mem_q [DEPTH];

  logic                 pop, push, space;
  logic                 any_grant;
  logic [ID_W-1:0]      grant_id;
  logic [ID_W-1:0]      grant_off;
  logic [ID_W:0]        grant_sum;
  logic [2*NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0]   grant;
  logic [EntW-1:0]      wdata;

  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign space     = (count_q < CNT_W'(DEPTH)) | pop;
  assign push      = any_grant;
  assign wdata     = {mul_p, mul_flags, grant_id};

  // Round-robin search: rotate requests so rr_ptr sits at bit 0, take the first set bit.
  always_comb begin
    any_grant = 1'b0;
    grant_off = '0;
    grant_sum = '0;
    grant_id  = '0;
    grant     = '0;
    req_rot   = {req_valid, req_valid} >> rr_ptr_q;
    if (space && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!any_grant && req_rot[k]) begin
          any_grant = 1'b1;
          grant_off = ID_W'(k);
        end
      end
    end
    if (any_grant) begin
      grant_sum = {1'b0, rr_ptr_q} + {1'b0, grant_off};
      if (grant_sum >= (ID_W + 1)'(NUM_REQ)) begin
        grant_sum = grant_sum - (ID_W + 1)'(NUM_REQ);
      end
      grant_id = grant_sum[ID_W-1:0];
      grant    = NUM_REQ'(1) << grant_id;
    end
  end

  assign req_ready = grant;

  // Steer the granted requester's operands to the shared multiplier; zero when idle.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mul_a = req_a[16*i +: 16];
        mul_b = req_b[16*i +: 16];
      end
    end
  end

  // Next-state for pointers, occupancy, registered head and sticky flags.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) begin
      rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    head_d = head_q;
    if (count_d != '0) begin
      // When nothing older remains, the entry being pushed becomes the head directly.
      if ((count_q - CNT_W'(pop)) == '0) begin
        head_d = wdata;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
    sticky_d = (sticky_clr ? 6'b0 : sticky_q) | (push ? mul_flags : 6'b0);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      sticky_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      sticky_q <= sticky_d;
    end
  end

  // FIFO storage; contents are only meaningful under the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rsp_p        = head_q[EntW-1 -: 16];
  assign rsp_flags    = head_q[ID_W +: 6];
  assign rsp_id       = head_q[ID_W-1:0];
  assign sticky_flags = sticky_q;
  assign fifo_count   = count_q;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter with a simple stand-in multiplier model.
module tb_fp16_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [15:0] mul_a, mul_b, mul_p;
  logic [5:0]  mul_flags;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_p;
  logic [5:0]  rsp_flags;
  logic [1:0]  rsp_id;
  logic [5:0]  sticky_flags;
  logic        sticky_clr = 1'b0;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  fp16_mul_arbiter #(
    .NUM_REQ(4),
    .DEPTH  (4),
    .ID_W   (2),
    .CNT_W  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_p       (mul_p),
    .mul_flags   (mul_flags),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_p       (rsp_p),
    .rsp_flags   (rsp_flags),
    .rsp_id      (rsp_id),
    .sticky_flags(sticky_flags),
    .sticky_clr  (sticky_clr),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: one real product, otherwise sum with flags from b[5:0].
  function automatic logic [21:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    if (a == 16'h3C00 && b == 16'h4000) return {16'h4000, 6'b000001};
    s = a + b;
    return {s, b[5:0]};
  endfunction

  always_comb {mul_p, mul_flags} = model(mul_a, mul_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = 16'h1000 * 16'(i + 1);
      req_b[16*i +: 16] = 16'(i);
    end
  endtask

  initial begin
    load_ops();
    req_valid = 4'hF;
    // Reset state
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_mul_a", 32'(mul_a), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_sticky", 32'(sticky_flags), 32'h0);
    check("rst_rsp_p", 32'(rsp_p), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);

    // Contention: all requesters valid, consumer always ready
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("cont_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      check("cont_id", 32'(rsp_id), 32'(k % 4));
      check("cont_p", 32'(rsp_p), 32'(16'h1000 * 16'((k % 4) + 1) + 16'(k % 4)));
      check("cont_count", 32'(fifo_count), 32'h1);
    end
    req_valid = 4'h0;
    tick();
    check("cont_drain", 32'(fifo_count), 32'h0);

    // Clear sticky with no accept
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    check("clr_sticky", 32'(sticky_flags), 32'h0);

    // Single op from requester 2
    rsp_ready = 1'b0;
    req_a[47:32] = 16'h3C00;
    req_b[47:32] = 16'h4000;
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    check("single_mul_a", 32'(mul_a), 32'h3C00);
    check("single_mul_b", 32'(mul_b), 32'h4000);
    tick();
    req_valid = 4'h0;
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_p", 32'(rsp_p), 32'h4000);
    check("single_id", 32'(rsp_id), 32'h2);
    check("single_flags", 32'(rsp_flags), 32'h1);
    check("single_sticky", 32'(sticky_flags), 32'h1);
    rsp_ready = 1'b1;
    tick();
    check("single_pop", 32'(fifo_count), 32'h0);

    // Backpressure: rr_ptr is 3, so accepts go 3,0,1,2
    load_ops();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_grant", 32'(req_ready), 32'(4'b0001 << ((3 + k) % 4)));
      tick();
    end
    check("bp_full", 32'(fifo_count), 32'h4);
    check("bp_stall", 32'(req_ready), 32'h0);
    tick();
    check("bp_full2", 32'(fifo_count), 32'h4);
    check("bp_stall2", 32'(req_ready), 32'h0);
    check("bp_head", 32'(rsp_id), 32'h3);
    rsp_ready = 1'b1;
    #1;
    check("bp_push_pop", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'h0;
    check("bp_count_hold", 32'(fifo_count), 32'h4);
    for (int j = 0; j < 4; j++) begin
      check("bp_order_id", 32'(rsp_id), 32'(j));
      check("bp_order_p", 32'(rsp_p), 32'(16'h1000 * 16'(j + 1) + 16'(j)));
      tick();
    end
    check("bp_empty", 32'(fifo_count), 32'h0);

    // Sticky: accept with clear in the same cycle, then clear alone
    rsp_ready = 1'b0;
    req_a[15:0] = 16'h0100;
    req_b[15:0] = 16'h0020;
    req_valid = 4'b0001;
    sticky_clr = 1'b1;
    #1;
    check("sticky_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'h0;
    check("sticky_survive", 32'(sticky_flags), 32'h20);
    check("sticky_rsp_p", 32'(rsp_p), 32'h0120);
    tick();
    sticky_clr = 1'b0;
    check("sticky_cleared", 32'(sticky_flags), 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset mid-operation: three queued, one being granted
    load_ops();
    req_valid = 4'b0010;
    tick();
    tick();
    tick();
    check("mid_count3", 32'(fifo_count), 32'h3);
    req_valid = 4'b0110;
    #1;
    check("mid_grant", 32'(req_ready), 32'h4);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_count", 32'(fifo_count), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_mul_a", 32'(mul_a), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'h0;
    check("post_rst_count", 32'(fifo_count), 32'h1);
    check("post_rst_id", 32'(rsp_id), 32'h1);

    // Idle
    #1;
    check("idle_mul_a", 32'(mul_a), 32'h0);
    check("idle_mul_b", 32'(mul_b), 32'h0);
    check("idle_ready", 32'(req_ready), 32'h0);
    tick();
    check("idle_count", 32'(fifo_count), 32'h1);
    check("idle_id", 32'(rsp_id), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp16_mul_arbiter.md
Name: fp16_mul_arbiter

Overview:
- Shares one combinational FP16 multiplier (fp16 op_a/op_b in, product plus six class flags out) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on each requester port.
- Each product is tagged with the requester id and buffered in a result FIFO toward a single response port.
- Keeps a sticky exception/class status register for software readout.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
DEPTH, 4, result FIFO entries (power of two, >=2)
ID_W, 2, requester id width, = clog2(NUM_REQ)
CNT_W, 3, FIFO count width, = clog2(DEPTH+1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester operation request
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a  in  16*NUM_REQ  operand A, requester i at [16i+15:16i]
req_b  in  16*NUM_REQ  operand B, same packing
mul_a  out  16  operand A to shared multiplier
mul_b  out  16  operand B to shared multiplier
mul_p  in  16  product from multiplier (combinational from mul_a/mul_b)
mul_flags  in  6  {sNaN,qNaN,infinity,zero,subnormal,normal}, bit5..bit0
rsp_valid  out  1  FIFO head valid
rsp_ready  in  1  consumer accepts head
rsp_p  out  16  head product
rsp_flags  out  6  head flags, same bit order as mul_flags
rsp_id  out  ID_W  head requester id
sticky_flags  out  6  OR of flags of all accepted ops since reset/clear
sticky_clr  in  1  synchronous clear of sticky_flags
fifo_count  out  CNT_W  current FIFO occupancy

Behaviour:
- Reset (async, rst=1):
  - FIFO empty, fifo_count=0, rsp_valid=0.
  - rsp_p, rsp_flags and rsp_id are 0.
  - sticky_flags=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 and mul_a=mul_b=0x0000 while rst is high.
  - An op in flight at reset is discarded. No response is produced for it.
- pop = rsp_valid & rsp_ready.
- space = (fifo_count < DEPTH) | pop. Push and pop are allowed in the same cycle while full.
- Arbitration (combinational, each cycle):
  - If space=1, grant the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready = one-hot grant; all zero if there is no valid request or space=0.
  - req_ready depends combinationally on req_valid.
- mul_a/mul_b = operands of the granted requester. They are 0x0000 when there is no grant.
- Accept:
  - accept = any req_valid[i] & req_ready[i].
  - At that clock edge, push {mul_p, mul_flags, i} into the FIFO and set rr_ptr = (i+1) mod NUM_REQ.
  - rr_ptr is unchanged when there is no accept.
- Latency:
  - An op accepted at edge N appears at the FIFO head after edge N if the FIFO was empty or popped at N.
  - Otherwise it appears after all older entries have been popped.
  - Ordering is strictly FIFO.
- FIFO:
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
  - fifo_count is +1 on push only, -1 on pop only, unchanged on both or neither.
  - rsp_* is the registered head entry. Its value is don't-care when rsp_valid=0; the RTL holds the last value.
- Requester handshake: a requester must hold req_valid and its operands stable until req_ready. The block does not check this.
- sticky_flags next = (sticky_clr ? 0 : sticky_flags) | (accept ? mul_flags : 0). Flags from an accept in the same cycle as a clear survive.
- There is no internal FSM beyond the FIFO and pointer registers. The block never deadlocks while rsp_ready is eventually asserted.

Test Plan:
- Single op: requester 2 drives a=0x3C00, b=0x4000, multiplier model returns 0x4000/6'b000001. Required: req_ready=4'b0100 in that cycle; one cycle later rsp_valid=1, rsp_p=0x4000, rsp_id=2, rsp_flags=6'b000001; sticky_flags=6'b000001.
- Contention: all four req_valid held high, rsp_ready=1. Required: grants 0,1,2,3,0,1 on consecutive cycles; rsp_id sequence matches one cycle later; fifo_count stays ≤1.
- Backpressure: rsp_ready=0 with requests pending. Required: exactly 4 accepts, then fifo_count=4 and req_ready=0 thereafter. When rsp_ready=1 is raised, a new accept occurs in the same cycle as the pop, fifo_count stays 4, and entries drain in accept order.
- Sticky: accept an op returning 6'b100000 (sNaN) with sticky_clr=1 in the same cycle. Required: sticky_flags=6'b100000. Next cycle, sticky_clr=1 with no accept. Required: sticky_flags=0.
- Reset mid-operation: assert rst with 3 entries queued and a request being granted. Required: immediately rsp_valid=0, fifo_count=0, req_ready=0. After release, the first grant goes to the lowest-index valid requester (rr_ptr=0).
- Idle: no req_valid. Required: mul_a=mul_b=0x0000, req_ready=0, no FIFO change.
